// File: rtl/i2s_wb_pkg.sv
// Shared definitions for the multi-channel audio Wishbone register file:
// register word offsets, control/status/interrupt bit positions, commit FSM states.
package i2s_wb_pkg;

  // Word offsets (byte address bits [7:2])
  localparam logic [5:0] OffCtrl       = 6'h00;
  localparam logic [5:0] OffStat       = 6'h01;
  localparam logic [5:0] OffFifoLow    = 6'h02;
  localparam logic [5:0] OffFifoLevel  = 6'h03;
  localparam logic [5:0] OffIrqEn      = 6'h04;
  localparam logic [5:0] OffIrqStat    = 6'h05;
  localparam logic [5:0] OffUnderrun   = 6'h06;
  localparam logic [5:0] OffSampleBase = 6'h08;

  localparam int unsigned CtrlDacMode    = 0;
  localparam int unsigned CtrlAutoCommit = 1;

  localparam int unsigned StatLow     = 0;
  localparam int unsigned StatEmpty   = 1;
  localparam int unsigned StatFull    = 2;
  localparam int unsigned StatPending = 3;

  localparam int unsigned IrqLow   = 0;
  localparam int unsigned IrqEmpty = 1;
  localparam int unsigned IrqXfer  = 2;
  localparam int unsigned IrqW     = 3;

  typedef enum logic {StIdle, StPend} commit_state_e;

  // Replace the byte lanes of old_val selected by sel with those of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/i2s_wb_irq_ctrl.sv
// Interrupt controller: edge detectors on FIFO status, sticky W1C status bits
// (set beats a same-cycle clear), enable mask and the interrupt line.
module i2s_wb_irq_ctrl
  import i2s_wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_low,
  input  logic            fifo_empty,
  input  logic            frame_xfer,
  input  logic [IrqW-1:0] irq_en,
  input  logic            clr_valid,
  input  logic [IrqW-1:0] clr_mask,
  output logic [IrqW-1:0] irq_stat,
  output logic            empty_rise,
  output logic            irq
);

  logic            low_q, empty_q;
  logic [IrqW-1:0] stat_q, stat_d, set_bits;

  assign empty_rise = fifo_empty && !empty_q;

  // Next sticky status: clear first, then set so a new event is never lost.
  always_comb begin
    set_bits           = '0;
    set_bits[IrqLow]   = fifo_low && !low_q;
    set_bits[IrqEmpty] = empty_rise;
    set_bits[IrqXfer]  = frame_xfer;
    stat_d             = stat_q;
    if (clr_valid) stat_d = stat_d & ~clr_mask;
    stat_d = stat_d | set_bits;
  end

  // Edge-detector history and status register.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_q   <= 1'b0;
      empty_q <= 1'b0;
      stat_q  <= '0;
    end else begin
      low_q   <= fifo_low;
      empty_q <= fifo_empty;
      stat_q  <= stat_d;
    end
  end

  assign irq_stat = stat_q;
  assign irq      = |(stat_q & irq_en);

endmodule

// File: rtl/i2s_wb_regfile_mc.sv
// Multi-channel audio Wishbone register file: per-channel sample staging, committed
// frame handshake to the audio FIFO with stall backpressure, and a maskable interrupt.
// Optional build macro: I2S_WB_UNDERRUN_CNT_EN adds the saturating underrun counter.
module i2s_wb_regfile_mc
  import i2s_wb_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SAMPLE_W      = 24,
  parameter int unsigned FIFO_LEN_BITS = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h9000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  input  logic [3:0]                   wb_sel_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_stall_o,
  output logic [NUM_CH*SAMPLE_W-1:0]   audio_data,
  output logic                         audio_valid,
  input  logic                         audio_ready,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  input  logic                         fifo_low,
  input  logic [FIFO_LEN_BITS:0]       fifo_level,
  output logic [FIFO_LEN_BITS:0]       fifo_threshold,
  output logic                         dac_mode,
  output logic                         irq_o
);

  localparam int unsigned LvlW   = FIFO_LEN_BITS + 1;
  localparam int unsigned FrameW = NUM_CH * SAMPLE_W;
  localparam logic [5:0]  LastCh = 6'(NUM_CH - 1);

  commit_state_e state_q, state_d;

  logic [SAMPLE_W-1:0] staging_q [NUM_CH];
  logic [SAMPLE_W-1:0] staging_d [NUM_CH];
  logic [FrameW-1:0]   frame_next;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [LvlW-1:0]     thr_q, thr_d;
  logic [IrqW-1:0]     irq_en_q, irq_en_d, irq_stat;
  logic [31:0]         rdata, ctrl_m, thr_m, en_m, smerge;
  logic                hit, is_sample, wr_en, commit_req, accept, wr_acc, commit;
  logic                xfer, empty_rise;
  logic [5:0]          woff, ch_off;
  logic [1:0]          unused_adr;

  assign unused_adr = wb_adr_i[1:0];
  assign hit        = wb_adr_i[31:8] == BASE_ADDR[31:8];
  assign woff       = wb_adr_i[7:2];
  assign ch_off     = woff - OffSampleBase;
  assign is_sample  = (woff >= OffSampleBase) && (32'(ch_off) < NUM_CH);
  assign wr_en      = wb_stb_i && wb_we_i && hit;
  assign commit_req = wr_en && is_sample &&
                      ((wb_sel_i[3] && wb_dat_i[31]) ||
                       (ctrl_q[CtrlAutoCommit] && ch_off == LastCh));
  // Stall uses the registered state, so a commit right after a transfer costs a bubble.
  assign wb_stall_o = (state_q == StPend) && commit_req;
  assign accept     = wb_stb_i && !wb_stall_o;
  assign wr_acc     = accept && wr_en;
  assign commit     = wr_acc && commit_req;
  assign audio_valid = state_q == StPend;
  assign xfer        = audio_valid && audio_ready;

  // Staging next-state with this cycle's sample write merged in; also the frame to commit.
  always_comb begin
    smerge     = '0;
    frame_next = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      staging_d[n] = staging_q[n];
      if (wr_acc && is_sample && ch_off == 6'(n)) begin
        smerge       = merge_bytes(32'(staging_q[n]), wb_dat_i, wb_sel_i);
        staging_d[n] = smerge[SAMPLE_W-1:0];
      end
      frame_next[n*SAMPLE_W +: SAMPLE_W] = staging_d[n];
    end
  end

  // Control register next-state with byte-lane merging.
  always_comb begin
    ctrl_m   = merge_bytes(32'(ctrl_q), wb_dat_i, wb_sel_i);
    thr_m    = merge_bytes(32'(thr_q), wb_dat_i, wb_sel_i);
    en_m     = merge_bytes(32'(irq_en_q), wb_dat_i, wb_sel_i);
    ctrl_d   = (wr_acc && woff == OffCtrl)    ? ctrl_m[1:0]      : ctrl_q;
    thr_d    = (wr_acc && woff == OffFifoLow) ? thr_m[LvlW-1:0]  : thr_q;
    irq_en_d = (wr_acc && woff == OffIrqEn)   ? en_m[IrqW-1:0]   : irq_en_q;
  end

  // Commit FSM next-state: one frame in flight, released by the FIFO handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (commit) state_d = StPend;
      StPend:  if (audio_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef I2S_WB_UNDERRUN_CNT_EN
  logic [15:0] underrun_q, underrun_base;
  logic        committed_q, underrun_inc;

  assign underrun_inc  = empty_rise && (ctrl_q[CtrlDacMode] || committed_q);
  assign underrun_base = (wr_acc && woff == OffUnderrun) ? 16'd0 : underrun_q;

  // Saturating underrun counter; an increment beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q  <= '0;
      committed_q <= 1'b0;
    end else begin
      underrun_q  <= (underrun_inc && underrun_base != 16'hFFFF) ? underrun_base + 16'd1
                                                                 : underrun_base;
      if (commit) committed_q <= 1'b1;
    end
  end
`else
  logic unused_empty_rise;
  assign unused_empty_rise = empty_rise;
`endif

  // Read mux; misses, unmapped offsets and the write-only sample window read zero.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (woff)
        OffCtrl:      rdata = 32'(ctrl_q);
        OffStat:      rdata = 32'({audio_valid, fifo_full, fifo_empty, fifo_low});
        OffFifoLow:   rdata = 32'(thr_q);
        OffFifoLevel: rdata = 32'(fifo_level);
        OffIrqEn:     rdata = 32'(irq_en_q);
        OffIrqStat:   rdata = 32'(irq_stat);
`ifdef I2S_WB_UNDERRUN_CNT_EN
        OffUnderrun:  rdata = 32'(underrun_q);
`endif
        default:      rdata = '0;
      endcase
    end
  end

  // Registers, staging, committed frame and the Wishbone response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      thr_q      <= '0;
      irq_en_q   <= '0;
      audio_data <= '0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) staging_q[n] <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      thr_q    <= thr_d;
      irq_en_q <= irq_en_d;
      if (commit) audio_data <= frame_next;
      wb_ack_o <= accept;
      wb_dat_o <= (accept && !wb_we_i) ? rdata : '0;
      for (int unsigned n = 0; n < NUM_CH; n++) staging_q[n] <= staging_d[n];
    end
  end

  assign fifo_threshold = thr_q;
  assign dac_mode       = ctrl_q[CtrlDacMode];

  i2s_wb_irq_ctrl u_irq_ctrl (
    .clk        (clk),
    .rst        (rst),
    .fifo_low   (fifo_low),
    .fifo_empty (fifo_empty),
    .frame_xfer (xfer),
    .irq_en     (irq_en_q),
    .clr_valid  (wr_acc && woff == OffIrqStat && wb_sel_i[0]),
    .clr_mask   (wb_dat_i[IrqW-1:0]),
    .irq_stat   (irq_stat),
    .empty_rise (empty_rise),
    .irq        (irq_o)
  );

endmodule
